// File: rtl/cic_interpolator_if.sv
`default_nettype none
// ============================================================================
// Module      : cic_interpolator_if
// Description : Sample/control bundle between a baseband source and the CIC
//               interpolator. satOvf exists only with CIC_INTERP_SAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
interface cic_interpolator_if #(
    parameter int IN_W  = 18,
    parameter int OUT_W = 18
);
    logic             sync;
    logic [14:0]      interpolation;
    logic [5:0]       gainShift;
    logic [IN_W-1:0]  in;
    logic             sampleStrobe;
    logic [OUT_W-1:0] out;
    logic             syncOut;
`ifdef CIC_INTERP_SAT_EN
    logic             satOvf;

    modport master (output sync, interpolation, gainShift, in,
                    input  sampleStrobe, out, syncOut, satOvf);
    modport slave  (input  sync, interpolation, gainShift, in,
                    output sampleStrobe, out, syncOut, satOvf);
`else
    modport master (output sync, interpolation, gainShift, in,
                    input  sampleStrobe, out, syncOut);
    modport slave  (input  sync, interpolation, gainShift, in,
                    output sampleStrobe, out, syncOut);
`endif
endinterface
`default_nettype wire

// File: rtl/cic_interpolator.sv
`default_nettype none
// ============================================================================
// Module      : cic_interpolator
// Description : Third-order CIC interpolator, R = interpolation+1, gain
//               normalised by arithmetic right shift. Define CIC_INTERP_SAT_EN
//               for saturating output plus sticky satOvf flag.
// Revision    : 1.0 - initial release
// ============================================================================
module cic_interpolator #(
    parameter int IN_W  = 18,
    parameter int ACC_W = 48,
    parameter int OUT_W = 18
) (
    input  wire logic         clk,
    input  wire logic         reset,
    cic_interpolator_if.slave bus
);
    localparam int c_PH_W = 15;

    logic [c_PH_W-1:0]       r_phase;
    logic signed [ACC_W-1:0] r_d0, r_d1, r_d2;
    logic signed [ACC_W-1:0] r_i0, r_i1, r_i2;
    logic [OUT_W-1:0]        r_out;
    logic                    r_sync_out;

    logic                    w_load;
    logic signed [ACC_W-1:0] w_x, w_c1, w_c2, w_c3, w_stuffed;
    logic [OUT_W-1:0]        w_fmt;

    assign w_load    = bus.sync && (r_phase == '0);
    assign w_x       = {{(ACC_W-IN_W){bus.in[IN_W-1]}}, bus.in};
    assign w_c1      = w_x  - r_d0;
    assign w_c2      = w_c1 - r_d1;
    assign w_c3      = w_c2 - r_d2;
    assign w_stuffed = w_load ? w_c3 : '0;

`ifdef CIC_INTERP_SAT_EN
    localparam logic signed [ACC_W-1:0] c_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] c_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic signed [ACC_W-1:0] w_shifted;
    logic                    w_hi, w_lo;
    logic                    r_sat;

    assign w_shifted = r_i2 >>> bus.gainShift;
    assign w_hi      = w_shifted > c_MAX;
    assign w_lo      = w_shifted < c_MIN;
    assign w_fmt     = w_hi ? c_MAX[OUT_W-1:0] :
                       w_lo ? c_MIN[OUT_W-1:0] : w_shifted[OUT_W-1:0];
    assign bus.satOvf = r_sat;
`else
    // Plain truncation: the caller chooses gainShift so the result fits.
    assign w_fmt = OUT_W'(r_i2 >>> bus.gainShift);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_phase    <= '0;
            r_d0       <= '0;
            r_d1       <= '0;
            r_d2       <= '0;
            r_i0       <= '0;
            r_i1       <= '0;
            r_i2       <= '0;
            r_out      <= '0;
            r_sync_out <= 1'b0;
`ifdef CIC_INTERP_SAT_EN
            r_sat      <= 1'b0;
`endif
        end else begin
            r_sync_out <= bus.sync;
            if (bus.sync) begin
                // interpolation is only looked at on reload, so a mid-period
                // change waits for the next load.
                if (w_load) begin
                    r_phase <= bus.interpolation;
                    r_d0    <= w_x;
                    r_d1    <= w_c1;
                    r_d2    <= w_c2;
                end else begin
                    r_phase <= r_phase - c_PH_W'(1);
                end
                r_i0  <= r_i0 + w_stuffed;
                r_i1  <= r_i1 + r_i0;
                r_i2  <= r_i2 + r_i1;
                r_out <= w_fmt;
`ifdef CIC_INTERP_SAT_EN
                if (w_hi || w_lo) begin
                    r_sat <= 1'b1;
                end
`endif
            end
        end
    end

    assign bus.sampleStrobe = w_load;
    assign bus.out          = r_out;
    assign bus.syncOut      = r_sync_out;
endmodule
`default_nettype wire

// File: tb/tb_cic_interpolator.sv
`default_nettype none
// ============================================================================
// Module      : tb_cic_interpolator
// Description : Self-checking bench; reference is the zero-stuffed input
//               convolved with the cubed length-R boxcar response.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cic_interpolator;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cic_interpolator_if bif ();
    cic_interpolator dut (.clk(clk), .reset(reset), .bus(bif.slave));

    int          total = 0;
    int          bad   = 0;
    int          rr;
    int          gs;
    int          n;
    longint      h[];
    longint      sx[$];
    logic [17:0] exp_out;
    bit          exp_sat;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d (sync #%0d)", tag, obs, exp, n);
        end
    endtask

    function automatic bit clamps(input longint v);
        return (v > 131071) || (v < -131072);
    endfunction

    function automatic logic [17:0] fmt(input longint v);
        logic [63:0] t;
`ifdef CIC_INTERP_SAT_EN
        if (v > 131071) v = 131071;
        else if (v < -131072) v = -131072;
`endif
        t = v;
        return t[17:0];
    endfunction

    // CIC impulse response: boxcar of length R convolved with itself three times.
    task automatic build_h(input int r);
        longint t[];
        h = new[1];
        h[0] = 1;
        repeat (3) begin
            t = new[h.size() + r - 1];
            foreach (t[i]) t[i] = 0;
            for (int i = 0; i < h.size(); i++)
                for (int j = 0; j < r; j++)
                    t[i+j] += h[i];
            h = t;
        end
    endtask

    task automatic do_reset(input int interp, input int g);
        reset             = 1'b1;
        bif.sync          = 1'($urandom % 2);
        bif.in            = '0;
        bif.interpolation = 15'(interp);
        bif.gainShift     = 6'(g);
        repeat (2) @(posedge clk);
        #1;
        check("rst_out", 32'(bif.out), 32'd0);
        check("rst_syncOut", 32'(bif.syncOut), 32'd0);
`ifdef CIC_INTERP_SAT_EN
        check("rst_satOvf", 32'(bif.satOvf), 32'd0);
`endif
        reset   = 1'b0;
        n       = 0;
        sx.delete();
        exp_out = '0;
        exp_sat = 1'b0;
        rr      = interp + 1;
        gs      = g;
        build_h(rr);
    endtask

    task automatic step(input bit s, input int x);
        longint acc;
        int     k;
        bit     ld;
        bif.sync = s;
        bif.in   = x[17:0];
        #1;
        ld = (n % rr) == 0;
        check("sampleStrobe", 32'(bif.sampleStrobe), 32'(s && ld));
        if (s) begin
            sx.push_back(ld ? longint'($signed(bif.in)) : 64'sd0);
            if (n >= 3) begin
                acc = 0;
                k   = n - 3;
                for (int j = 0; j < h.size() && j <= k; j++)
                    acc += h[j] * sx[k-j];
                acc = acc >>> gs;
                exp_out = fmt(acc);
                if (clamps(acc)) exp_sat = 1'b1;
            end else begin
                exp_out = '0;
            end
            n++;
        end
        @(posedge clk);
        #1;
        check("syncOut", 32'(bif.syncOut), 32'(s));
        check("out", 32'(bif.out), 32'(exp_out));
`ifdef CIC_INTERP_SAT_EN
        check("satOvf", 32'(bif.satOvf), 32'(exp_sat));
`endif
    endtask

    initial begin
        // Impulse, R=4
        do_reset(3, 0);
        step(1'b1, 1);
        repeat (20) step(1'b1, 0);

        // DC, R=4, gain 16 normalised by shift 4
        do_reset(3, 4);
        repeat (30) step(1'b1, 1000);

        // Impulse with random stalls
        do_reset(3, 0);
        repeat (60) step(1'($urandom % 2), (n == 0) ? 1 : 0);

        // R=1 ramp: pure 3-sync delay
        do_reset(0, 0);
        repeat (20) step(1'b1, 5 + n);

        // Overflow: DC gain 16 on +100000
        do_reset(3, 0);
        repeat (24) step(1'b1, 100000);

        // Reset mid DC run, then R=8 with shift 6 on -512, random stalls
        do_reset(3, 4);
        repeat (10) step(1'b1, 1000);
        do_reset(7, 6);
        repeat (80) step(1'($urandom % 4 != 0), -512);

        // Random segments: random R, shift and full-range samples
        for (int seg = 0; seg < 4; seg++) begin
            do_reset($urandom_range(0, 5), (seg == 3) ? 50 : $urandom_range(0, 8));
            repeat (50) step(1'($urandom % 4 != 0), int'($urandom_range(0, 262143)) - 131072);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
